// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART host-command framer.
// Host frame layout: HDR0 HDR1 <opcode> TRL.
package uart_cmd_pkg;

  localparam logic [7:0] HDR0    = 8'h00;
  localparam logic [7:0] HDR1    = 8'h01;
  localparam logic [7:0] TRL     = 8'h00;
  localparam logic [7:0] OP_INIT = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;

  // Parser states; S_HOLD means a command is waiting for the SD controller.
  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_OP,
    S_TRL,
    S_HOLD
  } state_t;

  // Error causes reported alongside the err strobe.
  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'd0,
    ERR_BAD_OP  = 2'd1,
    ERR_BAD_TRL = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  // True for the opcodes the SD controller understands.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_INIT) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle timer. Counts while a frame is partially received and
// flags the cycle in which the idle gap reaches TIMEOUT_CYC cycles.
module frame_timer #(
  parameter int TIMEOUT_CYC = 200000,
  parameter int TMR_W       = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] count_reg;

  // Idle counter: zero outside a frame or on any byte, saturates at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || !en) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + TMR_W'(1);
    end
  end

  assign expire = en && (count_reg == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-stream framer: recognises HDR0 HDR1 <op> TRL frames from the UART
// receiver and presents one command per frame to the SD controller over a
// valid/ready handshake. Framing errors, stalls and overruns raise err.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000,
  parameter int TMR_W       = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_op,
  input  logic       cmd_ready,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  state_t     state_reg, state_next, parse_state;
  logic [7:0] cmd_op_reg, cmd_op_next;
  logic       cmd_valid_reg, busy_reg, err_reg, err_next;
  err_code_t  err_code_reg, err_code_next;
  logic       xfer, timer_en, timer_expire;

  // A handshake completes whenever a pending command meets cmd_ready.
  assign xfer     = cmd_valid_reg && cmd_ready;
  assign timer_en = (state_reg == S_HDR1) || (state_reg == S_OP) ||
                    (state_reg == S_TRL);

  frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_frame_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_valid),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Next-state logic; a byte in the handshake cycle is parsed as a fresh
  // frame start, since the pending command leaves in that same cycle.
  always_comb begin
    parse_state   = (state_reg == S_HOLD && xfer) ? S_HDR0 : state_reg;
    state_next    = parse_state;
    cmd_op_next   = cmd_op_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    if (rx_valid) begin
      case (parse_state)
        S_HDR0: begin
          if (rx_data == HDR0) state_next = S_HDR1;
        end
        S_HDR1: begin
          // A repeated 00 is taken as a new header start.
          if (rx_data == HDR1)      state_next = S_OP;
          else if (rx_data != HDR0) state_next = S_HDR0;
        end
        S_OP: begin
          if (is_opcode(rx_data)) begin
            cmd_op_next = rx_data;
            state_next  = S_TRL;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_BAD_OP;
            state_next    = S_HDR0;
          end
        end
        S_TRL: begin
          if (rx_data == TRL) begin
            state_next = S_HOLD;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_BAD_TRL;
            state_next    = S_HDR0;
          end
        end
        S_HOLD: begin
          // Command still pending: the byte is dropped.
          err_next      = 1'b1;
          err_code_next = ERR_OVERRUN;
        end
        default: state_next = S_HDR0;
      endcase
    end else if (timer_expire) begin
      err_next      = 1'b1;
      err_code_next = ERR_TIMEOUT;
      state_next    = S_HDR0;
    end
  end

  // State and output registers; every output is driven from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_HDR0;
      cmd_op_reg    <= 8'h00;
      cmd_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_OVERRUN;
    end else begin
      state_reg     <= state_next;
      cmd_op_reg    <= cmd_op_next;
      cmd_valid_reg <= (state_next == S_HOLD);
      busy_reg      <= (state_next != S_HDR0);
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
    end
  end

  assign cmd_valid = cmd_valid_reg;
  assign cmd_op    = cmd_op_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a table of hand-derived per-cycle vectors, a few
// directed corner sequences, and randomized traffic checked against a
// frame-level reference model. Byte gaps are compressed (TIMEOUT_CYC = 16).
module tb_uart_cmd_parser;

  localparam int T = 16;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  logic [7:0] cmd_op;
  logic       cmd_ready;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_parser #(.TIMEOUT_CYC(T), .TMR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  // m_pos: how many frame bytes have been matched (0 = waiting for a header).
  int         m_pos;
  bit         m_pend;
  logic [7:0] m_op;
  longint     cyc, m_last;
  bit         e_valid, e_busy, e_err;
  logic [7:0] e_op;
  logic [1:0] e_code;

  function automatic void model_reset();
    m_pos = 0; m_pend = 0; m_op = 8'h00; cyc = 0; m_last = 0;
    e_valid = 0; e_busy = 0; e_err = 0; e_op = 8'h00; e_code = 2'd0;
  endfunction

  // Advances the model by one clock cycle with the given inputs; the e_*
  // values are what the DUT must show after that clock edge.
  function automatic void model_step(input bit rv, input logic [7:0] rd, input bit rdy);
    bit fire = 0;
    logic [1:0] c = e_code;
    if (m_pend && rdy) m_pend = 0;       // command leaves this cycle
    if (rv) begin
      m_last = cyc;
      if (m_pend) begin
        fire = 1; c = 2'd0;
      end else begin
        case (m_pos)
          0: if (rd == 8'h00) m_pos = 1;
          1: if (rd == 8'h01) m_pos = 2; else if (rd != 8'h00) m_pos = 0;
          2: if (rd == 8'h02 || rd == 8'h03) begin m_op = rd; m_pos = 3; end
             else begin fire = 1; c = 2'd1; m_pos = 0; end
          default: if (rd == 8'h00) begin m_pend = 1; m_pos = 0; end
                   else begin fire = 1; c = 2'd2; m_pos = 0; end
        endcase
      end
    end else if (m_pos != 0 && (cyc - m_last) == T) begin
      fire = 1; c = 2'd3; m_pos = 0;
    end
    e_valid = m_pend;
    e_busy  = m_pend || (m_pos != 0);
    e_err   = fire;
    e_code  = c;
    e_op    = m_op;
    cyc++;
  endfunction

  // ---------------- checking helpers ----------------
  function automatic logic [12:0] dut_vec();
    return {cmd_valid, cmd_op, busy, err, err_code};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual{valid,op,busy,err,code}=%b_%h_%b_%b_%0d required=%b_%h_%b_%b_%0d",
               name, $time, act[12], act[11:4], act[3], act[2], act[1:0],
               req[12], req[11:4], req[3], req[2], req[1:0]);
    end
  endtask

  // One clock cycle: drive inputs, clock, update model, compare 1 ns later.
  task automatic step(input bit rv, input logic [7:0] rd, input bit rdy);
    rx_valid = rv; rx_data = rd; cmd_ready = rdy;
    @(posedge clk);
    model_step(rv, rd, rdy);
    #1;
    check("model", dut_vec(), {e_valid, e_op, e_busy, e_err, e_code});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rv; logic [7:0] rd; bit rdy;
    bit ev; logic [7:0] eop; bit ebusy; bit eerr; logic [1:0] ecode;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit rv, input logic [7:0] rd, input bit rdy,
                              input bit ev, input logic [7:0] eop, input bit ebusy,
                              input bit eerr, input logic [1:0] ecode);
    vec_t v;
    v.rv = rv; v.rd = rd; v.rdy = rdy; v.ev = ev; v.eop = eop;
    v.ebusy = ebusy; v.eerr = eerr; v.ecode = ecode;
    return v;
  endfunction

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 40) return 8'h00;
    if (r < 60) return 8'h01;
    if (r < 75) return 8'h02;
    if (r < 85) return 8'h03;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bit sparse;
    int n_cmd;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
    model_reset();
    #1;
    check("reset_values", dut_vec(), 13'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Init frame (ready=1), resync, bad opcode + READ, overrun, bad trailer,
    // non-01 in HDR1, byte during the handshake cycle.
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h00, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h01, Y,  N, 8'h00, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h02, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h00, Y,  Y, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(N, 8'h00, Y,  N, 8'h02, N, N, 2'd0));
    tbl.push_back(mk(N, 8'h00, Y,  N, 8'h02, N, N, 2'd0));
    tbl.push_back(mk(Y, 8'h55, Y,  N, 8'h02, N, N, 2'd0));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h01, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h02, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h00, Y,  Y, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(N, 8'h00, Y,  N, 8'h02, N, N, 2'd0));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h01, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h07, Y,  N, 8'h02, N, Y, 2'd1));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h02, Y, N, 2'd1));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h02, Y, N, 2'd1));
    tbl.push_back(mk(Y, 8'h01, Y,  N, 8'h02, Y, N, 2'd1));
    tbl.push_back(mk(Y, 8'h03, Y,  N, 8'h03, Y, N, 2'd1));
    tbl.push_back(mk(Y, 8'h00, Y,  Y, 8'h03, Y, N, 2'd1));
    tbl.push_back(mk(N, 8'h00, N,  Y, 8'h03, Y, N, 2'd1));
    tbl.push_back(mk(Y, 8'h00, N,  Y, 8'h03, Y, Y, 2'd0));
    tbl.push_back(mk(N, 8'h00, Y,  N, 8'h03, N, N, 2'd0));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h03, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h01, Y,  N, 8'h03, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h02, Y,  N, 8'h02, Y, N, 2'd0));
    tbl.push_back(mk(Y, 8'h05, Y,  N, 8'h02, N, Y, 2'd2));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h02, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h7F, Y,  N, 8'h02, N, N, 2'd2));
    tbl.push_back(mk(Y, 8'h00, N,  N, 8'h02, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h01, N,  N, 8'h02, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h03, N,  N, 8'h03, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h00, N,  Y, 8'h03, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h00, Y,  N, 8'h03, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h01, Y,  N, 8'h03, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h02, Y,  N, 8'h02, Y, N, 2'd2));
    tbl.push_back(mk(Y, 8'h00, Y,  Y, 8'h02, Y, N, 2'd2));
    tbl.push_back(mk(N, 8'h00, Y,  N, 8'h02, N, N, 2'd2));

    foreach (tbl[i]) begin
      step(tbl[i].rv, tbl[i].rd, tbl[i].rdy);
      check($sformatf("vec%0d", i), dut_vec(),
            {tbl[i].ev, tbl[i].eop, tbl[i].ebusy, tbl[i].eerr, tbl[i].ecode});
      $display("vec %0d rv=%b rd=%h rdy=%b -> valid=%b op=%h busy=%b err=%b code=%0d",
               i, tbl[i].rv, tbl[i].rd, tbl[i].rdy, cmd_valid, cmd_op, busy, err, err_code);
    end

    // Timeout: 00 01 then silence; err must appear after exactly T idle cycles.
    step(Y, 8'h00, N);
    step(Y, 8'h01, N);
    for (int j = 1; j <= T; j++) begin
      step(N, 8'h00, N);
      if (j < T) check("timeout_early", {11'h0, busy, err}, {11'h0, Y, N});
      else       check("timeout_exact", {9'h0, busy, err, err_code}, {9'h0, N, Y, 2'd3});
    end
    $display("timeout sequence: err=%b code=%0d busy=%b", err, err_code, busy);

    // Byte arriving in the expiry cycle wins over the timeout.
    step(Y, 8'h00, N);
    step(Y, 8'h01, N);
    for (int j = 1; j < T; j++) step(N, 8'h00, N);
    step(Y, 8'h02, N);
    check("timeout_byte_wins", {cmd_op, 3'b0, busy, err}, {8'h02, 3'b0, Y, N});
    step(Y, 8'h00, Y);
    step(N, 8'h00, Y);
    $display("byte-wins sequence: op=%h busy=%b", cmd_op, busy);

    // READ frame stalled by cmd_ready = 0 for 1000 cycles.
    step(Y, 8'h00, N); step(Y, 8'h01, N); step(Y, 8'h03, N); step(Y, 8'h00, N);
    for (int j = 0; j < 1000; j++) begin
      step(N, 8'h00, N);
      if (j % 250 == 0) check("stall_hold", {cmd_valid, cmd_op, busy, err, 2'b0},
                              {Y, 8'h03, Y, N, 2'b0});
    end
    step(N, 8'h00, Y);
    check("stall_release", {cmd_valid, 8'h0, busy, 3'b0}, 13'h0);
    $display("stall sequence: released op=%h after 1000 cycles", cmd_op);

    // Overrun while pending, then asynchronous reset in S_HOLD.
    step(Y, 8'h00, N); step(Y, 8'h01, N); step(Y, 8'h02, N); step(Y, 8'h00, N);
    step(Y, 8'h00, N);
    check("overrun", {cmd_valid, cmd_op, busy, err, err_code}, {Y, 8'h02, Y, Y, 2'd0});
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), 13'h0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", dut_vec(), 13'h0);
    rst_n = 1'b1;
    model_reset();
    $display("overrun + async reset sequence done");

    // Randomized traffic against the reference model.
    n_cmd = 0;
    sparse = 0;
    for (int k = 0; k < 4000; k++) begin
      bit rv, rdy;
      if (k % 64 == 0) sparse = ($urandom_range(0, 2) == 0);
      rv  = sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) == 0);
      if (cmd_valid && rdy) begin
        n_cmd++;
        $display("random xfer %0d op=%h at cycle %0d", n_cmd, cmd_op, k);
      end
      step(rv, rv ? rand_byte() : 8'h00, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command framer between the UART receiver and the SD card controller. Consumes received bytes (9600 baud on a 50 MHz `clk`), recognises the 4-byte host frame `00 01 <op> 00`, and issues one command per valid frame to the SD controller over a valid/ready handshake. Malformed frames, stalled frames and bytes arriving while a command is pending are reported on a one-cycle error strobe.

## Interface
- `TIMEOUT_CYC`, default 200000: maximum idle cycles between bytes inside a frame, about 4 ms at 50 MHz (one byte is about 52000 cycles).
- `TMR_W`, default 18: timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYC.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx_data`  in  8  received byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `cmd_valid`  out  1  a command is pending.
- `cmd_op`  out  8  opcode of the pending command; held stable while `cmd_valid` is high.
- `cmd_ready`  in  1  the SD controller accepts the command.
- `busy`  out  1  high in any state other than S_HDR0.
- `err`  out  1  one-cycle error strobe.
- `err_code`  out  2  error cause, valid when `err` is high: 0 overrun, 1 bad opcode, 2 bad trailer, 3 timeout.

## Operation
- States: S_HDR0, S_HDR1, S_OP, S_TRL, S_HOLD. Reset state is S_HDR0.
- Transitions on each `rx_valid` byte:
  - S_HDR0: byte 0x00 -> S_HDR1. Any other byte -> stay in S_HDR0 silently.
  - S_HDR1: byte 0x01 -> S_OP. Byte 0x00 -> stay in S_HDR1 (treated as a new header start). Any other byte -> S_HDR0, no error.
  - S_OP: byte 0x02 (INIT) or 0x03 (READ) -> latch into `cmd_op`, go to S_TRL. Any other byte -> `err` with code 1, go to S_HDR0.
  - S_TRL: byte 0x00 -> S_HOLD, `cmd_valid` rises. Any other byte -> `err` with code 2, go to S_HDR0, `cmd_op` unchanged.
  - S_HOLD: no frame parsing. Every arriving byte is dropped and raises `err` with code 0.
- Handshake:
  - Transfer happens in any cycle where `cmd_valid && cmd_ready`.
  - Next cycle: `cmd_valid` = 0, state = S_HDR0.
  - A byte arriving in the transfer cycle is processed as if the state were S_HDR0. It is not dropped and raises no error.
- Timeout:
  - The counter clears on every accepted byte. It counts in S_HDR1, S_OP and S_TRL only, and holds at 0 in S_HDR0 and S_HOLD.
  - When the count reaches TIMEOUT_CYC-1 and `rx_valid` is low: `err` with code 3, go to S_HDR0.
  - If `rx_valid` is high in that same cycle, the byte wins and no timeout is signalled.
- `cmd_ready` is ignored when `cmd_valid` is low.

## Timing
- Reset values: `cmd_valid` 0, `cmd_op` 0x00, `busy` 0, `err` 0, `err_code` 0, counter 0.
- All outputs are registered.
- `cmd_valid` is high in cycle N+1 when the trailer byte's `rx_valid` is in cycle N.
- `err`/`err_code` are high in cycle N+1 for the causing event in cycle N. `err_code` holds its last value when `err` is low.
- Throughput: one command per frame, with no limit on back-to-back frames.
- Asserting `rst_n` low mid-frame or in S_HOLD: everything returns to its reset value immediately, and the pending command is discarded.

## Structure
- Package `uart_cmd_pkg` holds:
  - constants HDR0 = 8'h00, HDR1 = 8'h01, TRL = 8'h00;
  - opcodes OP_INIT = 8'h02, OP_READ = 8'h03;
  - the state enum;
  - the err_code enum.
- Sub-module `frame_timer` (parameters `TIMEOUT_CYC`, `TMR_W`):
  - inputs `clr`, `en`;
  - output `expire`, high when the count equals TIMEOUT_CYC-1 and `en` is high.
- The parser FSM and output registers live in the top module.

## Test plan
- Init frame: bytes 00 01 02 00 at 9600 baud, `cmd_ready` tied to 1 -> `cmd_valid` high for exactly 1 cycle with `cmd_op` = 0x02, one cycle after the 4th `rx_valid`; `err` never high.
- Read frame with stall: bytes 00 01 03 00, `cmd_ready` held 0 for 1000 cycles then 1 -> `cmd_valid` high and `cmd_op` = 0x03 stable for 1000 cycles; `cmd_valid` and `busy` drop the cycle after the handshake.
- Resync: bytes 55 00 00 01 02 00 -> exactly one INIT command, no `err`.
- Bad opcode: bytes 00 01 07 00 -> `err` pulse with code 1 after the 3rd byte, no `cmd_valid`. A following 00 01 03 00 -> READ command issued.
- Timeout: bytes 00 01, then silence -> `err` code 3 exactly TIMEOUT_CYC cycles after the 2nd byte, `busy` 0 afterwards. Repeat with TIMEOUT_CYC = 16 using direct `rx_valid` pulses for exact cycle checking.
- Overrun and reset: a pending command held by `cmd_ready` = 0, then byte 00 -> `err` code 0. Pulse `rst_n` low -> `cmd_valid` = 0 and `cmd_op` = 0x00 asynchronously.
